dec_aes: RTL
============

# dec_aes

AES-128 single-block iterative decryptor (FIPS-197 inverse cipher), the receive-side counterpart of `enc_aes` in the AES path of the accelerator. It accepts a 128-bit ciphertext and 128-bit cipher key over a valid/ready handshake and expands the key forward to round key 10. It then runs ten inverse rounds, one per clock, deriving round keys backwards on the fly, and presents the plaintext over a second valid/ready handshake.

## Interface
- No parameters; block size and key size are fixed at 128 bits.
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: `in_data`/`in_key` valid.
- `in_ready` output 1: block can accept; high only in IDLE.
- `in_data` input 128: ciphertext, byte 0 = bits [127:120].
- `in_key` input 128: cipher key, same byte order.
- `out_valid` output 1: plaintext valid; held until accepted.
- `out_ready` input 1: consumer accepts plaintext.
- `out_data` output 128: plaintext, same byte order.
- `busy` output 1: high in KEYEXP or ROUND.

## Operation
- State bytes are column-major: byte k sits at row k%4, column k/4. Round-key word j is bytes 4j..4j+3.
- **IDLE**: `in_ready`=1. On `in_valid && in_ready`, latch `in_data` and `in_key` and go to KEYEXP with expansion counter 1.
- **KEYEXP** (10 cycles): each cycle applies the forward schedule step rk_i = f(rk_{i-1}, Rcon[i]), Rcon = 01,02,04,08,10,20,40,80,1b,36. On the cycle producing rk10, the state register loads ciphertext ^ rk10. Go to ROUND with r=9.
- **ROUND** (10 cycles, r = 9 down to 0):
  - Each cycle computes state ← InvMixColumns(InvSubBytes(InvShiftRows(state)) ^ rk_r). InvMixColumns is omitted when r=0.
  - rk_r comes from rk_{r+1} (words w0..w3): w3'=w3^w2, w2'=w2^w1, w1'=w1^w0, w0'=w0^SubWord(RotWord(w3'))^Rcon[r+1].
  - After r=0, load `out_data` and go to DONE.
- **DONE**: `out_valid`=1. On `out_ready`, go to IDLE; `in_ready` rises the following cycle. `out_data` holds its value until the next completion.
- `in_valid` outside IDLE is ignored. `in_data`/`in_key` may change freely once accepted.
- The forward S-box (key schedule) and inverse S-box (InvSubBytes) are exact FIPS-197 tables. GF(2^8) arithmetic uses the polynomial 0x11b.

## Timing
- Reset values: `in_ready`=0 during reset and 1 after release; `out_valid`=0, `out_data`=0, `busy`=0, state=IDLE, key cache invalid.
- Latency: acceptance edge E0 to `out_valid` high after edge E0+20 (10 KEYEXP + 10 ROUND). With a cache hit (see Configuration), `out_valid` is high after E0+10.
- Throughput: one block per 21 cycles minimum when `out_ready` is tied high (11 with cache hit).
- Same-cycle `out_ready` and `in_valid` in DONE: the output is accepted but the new input is not (`in_ready`=0). It is accepted next cycle.
- Reset asserted mid-operation: immediately returns to IDLE, clears outputs and invalidates the cache. No partial result is ever presented.

## Configuration
- `DEC_AES_KEY_CACHE_EN` defined:
  - After each KEYEXP, store `in_key` and rk10 with a valid flag.
  - On acceptance, if the cache is valid and `in_key` equals the cached key, skip KEYEXP. The state loads ciphertext ^ cached rk10 at the acceptance edge and goes straight to ROUND.
  - The cache is invalidated by reset only.
- `DEC_AES_KEY_CACHE_EN` undefined: no cache registers; every block runs KEYEXP; latency is always 20.

## Test plan
- Key 000102030405060708090a0b0c0d0e0f, ct 69c4e0d86a7b0430d8cdb78070b4c55a -> `out_data`=00112233445566778899aabbccddeeff, `out_valid` high exactly 20 cycles after acceptance.
- Key 2b7e151628aed2a6abf7158809cf4f3c, ct 3925841d02dc09fbdc118597196a0b32 -> 3243f6a8885a308d313198a2e0370734.
- Back-to-back blocks with the same key and `out_ready` held 0 for 5 cycles -> `out_valid` and `out_data` stay stable. `in_ready` stays low until the cycle after `out_ready`. Second latency is 10 with the macro defined, 20 without.
- Toggle `in_valid` and random `in_data` during ROUND -> no effect on the result.
- Assert `rst_n`=0 at round r=4 -> all outputs 0 immediately. A fresh vector-1 decryption afterwards takes the full 20 cycles and is correct, i.e. the cache was invalidated.
- Alternate keys vector1/vector2/vector1 -> all three plaintexts correct; with the cache enabled, no hit occurs.

Source files
------------

// File: rtl/dec_aes_if.sv
// Handshake bundle for dec_aes: ciphertext/key input channel, plaintext output channel, busy status.
interface dec_aes_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic [127:0] in_key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         busy;

  modport master (output in_valid, in_data, in_key, out_ready,
                  input  in_ready, out_valid, out_data, busy);
  modport slave  (input  in_valid, in_data, in_key, out_ready,
                  output in_ready, out_valid, out_data, busy);
endinterface

// File: rtl/dec_aes.sv
// AES-128 iterative decryptor: forward key expansion, then ten inverse rounds with backward key derivation.
// Optional round-key-10 cache enabled by defining DEC_AES_KEY_CACHE_EN.
module dec_aes (
  input logic      clk,
  input logic      rst_n,
  dec_aes_if.slave bus
);
  // state  | meaning
  // IDLE   | waiting for a block, in_ready high
  // KEYEXP | forward schedule rk1..rk10, cnt = 1..10
  // ROUND  | inverse round r = cnt, 9 down to 0
  // DONE   | plaintext presented until out_ready
  typedef enum logic [1:0] {S_IDLE, S_KEYEXP, S_ROUND, S_DONE} state_t;

  state_t       state, state_nxt;
  logic [127:0] st, rk, rk_fwd, rk_bwd, rnd_out, cache_rk;
  logic [3:0]   cnt;
  logic         accept, hit;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254; maps 0 to 0 as the S-box requires.
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] sq, acc;
    sq  = gmul(a, a);
    acc = sq;
    for (int i = 0; i < 6; i++) begin
      sq  = gmul(sq, sq);
      acc = gmul(acc, sq);
    end
    return acc;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = ginv(a);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    return ginv({a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05);
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] i);
    case (i)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [31:0] sub_rot(input logic [31:0] w);
    return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
  endfunction

  function automatic logic [127:0] key_fwd(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3;
    w0 = k[127:96] ^ sub_rot(k[31:0]) ^ {rc, 24'h0};
    w1 = k[95:64] ^ w0;
    w2 = k[63:32] ^ w1;
    w3 = k[31:0] ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  function automatic logic [127:0] key_bwd(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3;
    w3 = k[31:0] ^ k[63:32];
    w2 = k[63:32] ^ k[95:64];
    w1 = k[95:64] ^ k[127:96];
    w0 = k[127:96] ^ sub_rot(w3) ^ {rc, 24'h0};
    return {w0, w1, w2, w3};
  endfunction

  function automatic logic [127:0] inv_round(input logic [127:0] s, input logic [127:0] k,
                                             input logic last);
    logic [127:0] t, o;
    logic [7:0]   a0, a1, a2, a3;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        t[127-8*(4*c+r) -: 8] = inv_sbox(s[127-8*(4*((c-r+4)%4)+r) -: 8]) ^ k[127-8*(4*c+r) -: 8];
    if (last) return t;
    for (int c = 0; c < 4; c++) begin
      a0 = t[127-32*c -: 8];
      a1 = t[119-32*c -: 8];
      a2 = t[111-32*c -: 8];
      a3 = t[103-32*c -: 8];
      o[127-32*c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
      o[119-32*c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
      o[111-32*c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
      o[103-32*c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
    end
    return o;
  endfunction

  assign rk_fwd  = key_fwd(rk, rcon(cnt));
  assign rk_bwd  = key_bwd(rk, rcon(cnt + 4'd1));
  assign rnd_out = inv_round(st, rk_bwd, cnt == 4'd0);
  assign accept  = bus.in_valid && bus.in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.busy      = 1'b0;
    case (state)
      S_IDLE: begin
        bus.in_ready = rst_n;
        if (accept) state_nxt = hit ? S_ROUND : S_KEYEXP;
      end
      S_KEYEXP: begin
        bus.busy = 1'b1;
        if (cnt == 4'd10) state_nxt = S_ROUND;
      end
      S_ROUND: begin
        bus.busy = 1'b1;
        if (cnt == 4'd0) state_nxt = S_DONE;
      end
      S_DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st           <= '0;
      rk           <= '0;
      cnt          <= '0;
      bus.out_data <= '0;
    end else begin
      case (state)
        S_IDLE: if (accept) begin
          if (hit) begin
            st  <= bus.in_data ^ cache_rk;
            rk  <= cache_rk;
            cnt <= 4'd9;
          end else begin
            st  <= bus.in_data;
            rk  <= bus.in_key;
            cnt <= 4'd1;
          end
        end
        S_KEYEXP: begin
          rk <= rk_fwd;
          if (cnt == 4'd10) begin
            st  <= st ^ rk_fwd;
            cnt <= 4'd9;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        S_ROUND: begin
          st <= rnd_out;
          rk <= rk_bwd;
          if (cnt == 4'd0) bus.out_data <= rnd_out;
          else             cnt <= cnt - 4'd1;
        end
        default: ;
      endcase
    end
  end

`ifdef DEC_AES_KEY_CACHE_EN
  logic [127:0] cache_key;
  logic         cache_ok;

  // The key is captured at acceptance since in_key may change during KEYEXP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cache_key <= '0;
      cache_rk  <= '0;
      cache_ok  <= 1'b0;
    end else begin
      if (state == S_IDLE && accept && !hit) begin
        cache_key <= bus.in_key;
        cache_ok  <= 1'b0;
      end
      if (state == S_KEYEXP && cnt == 4'd10) begin
        cache_rk <= rk_fwd;
        cache_ok <= 1'b1;
      end
    end
  end

  assign hit = cache_ok && (bus.in_key == cache_key);
`else
  assign cache_rk = '0;
  assign hit      = 1'b0;
`endif
endmodule
